fence_flush_seq: RTL and testbench

- Sequences memory-ordering operations: FENCE, FENCE.I and SFENCE.VMA from the commit stage.
- Drains the store buffer and write-through write buffer, optionally flushes/invalidates the D$, then flushes the I$ and/or TLBs.
- Holds issue (halt_o) while busy; reports completion with a one-cycle pulse.
- Sits between the commit stage and the cache subsystem.

---
 rtl/fence_seq_pkg.sv | 33 +++
 rtl/fence_seq_cycle_cnt.sv | 40 ++++
 rtl/fence_flush_seq.sv | 152 +++++++++++++++
 tb/tb_fence_flush_seq.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fence_seq_pkg.sv
// Shared types for the fence/flush sequencer.
//   fence_op_e    : normalised memory-ordering op latched at accept
//   fence_state_e : sequencer FSM states
//   decode_op()   : maps the raw commit-stage op code onto fence_op_e
package fence_seq_pkg;

  localparam int FENCE_OP_W = 2;

  typedef enum logic [FENCE_OP_W-1:0] {
    FENCE      = 2'd0,
    FENCE_I    = 2'd1,
    SFENCE_VMA = 2'd2
  } fence_op_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DRAIN     = 3'd1,
    FLUSH_DC  = 3'd2,
    INV_IC    = 3'd3,
    FLUSH_TLB = 3'd4,
    DONE      = 3'd5
  } fence_state_e;

  // Code 3 is reserved and behaves as a plain FENCE.
  function automatic fence_op_e decode_op(input logic [FENCE_OP_W-1:0] code);
    case (code)
      2'd1:    return FENCE_I;
      2'd2:    return SFENCE_VMA;
      default: return FENCE;
    endcase
  endfunction

endpackage

// File: rtl/fence_seq_cycle_cnt.sv
// Saturating cycle counter for fence latency reporting.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : restart the count (op accepted)
//   inc_i        : count this cycle
//   cap_i        : publish the count including this cycle to cycles_o
//   cycles_o     : last published count, held until the next capture
module fence_seq_cycle_cnt #(
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic                cap_i,
  output logic [CntWidth-1:0] cycles_o
);

  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_inc;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CntWidth'(1'b1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      cycles_o <= '0;
    end else begin
      if (clr_i) begin
        cnt_q <= '0;
      end else if (inc_i) begin
        cnt_q <= cnt_inc;
      end
      // The capture cycle itself is a busy cycle, so publish the bumped value.
      if (cap_i) begin
        cycles_o <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/fence_flush_seq.sv
// Fence / flush sequencer between commit and the cache subsystem.
// Drains the store and write buffers, optionally flushes the D$, then
// invalidates the I$ and/or flushes the TLBs, and pulses done_o.
//
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   fence_valid_i/op_i     : op request from commit (op 3 treated as FENCE)
//   fence_ready_o          : request accepted when valid && ready
//   done_o                 : one-cycle completion pulse
//   busy_o, halt_o         : sequencer active / stall issue (identical)
//   sb_empty_i             : store buffer empty
//   wbuf_empty_i           : write-through write buffer empty
//   dcache_flush_o         : D$ flush request, level until ack
//   dcache_invalidate_o    : flush also invalidates (only with dcache_flush_o)
//   dcache_flush_ack_i     : single-cycle D$ flush completion
//   icache_flush_o         : one-cycle I$ invalidate pulse
//   tlb_flush_o            : one-cycle TLB flush pulse
//   fence_cycles_o         : busy cycles of the last op (FENCE_SEQ_PERF_EN only)
//
// Build option: define FENCE_SEQ_PERF_EN to add the fence_cycles_o counter.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | ready for a request
// DRAIN     | waiting for store buffer (and write buffer if WT) empty
// FLUSH_DC  | D$ flush requested, waiting for ack
// INV_IC    | one-cycle I$ invalidate
// FLUSH_TLB | one-cycle TLB flush
// DONE      | one-cycle completion pulse
module fence_flush_seq
  import fence_seq_pkg::*;
#(
  parameter bit WtCache                 = 1'b1,
  parameter bit DcacheFlushOnFence      = 1'b0,
  parameter bit DcacheInvalidateOnFlush = 1'b0,
  parameter int CntWidth                = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fence_valid_i,
  input  logic [FENCE_OP_W-1:0] fence_op_i,
  output logic                  fence_ready_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  halt_o,
  input  logic                  sb_empty_i,
  input  logic                  wbuf_empty_i,
  output logic                  dcache_flush_o,
  output logic                  dcache_invalidate_o,
  input  logic                  dcache_flush_ack_i,
  output logic                  icache_flush_o,
  output logic                  tlb_flush_o
`ifdef FENCE_SEQ_PERF_EN
  ,
  output logic [CntWidth-1:0]   fence_cycles_o
`endif
);

  if (CntWidth < 1) begin : g_cnt_width_chk
    $error("fence_flush_seq: CntWidth must be at least 1");
  end

  fence_state_e state_q, state_d;
  fence_op_e    op_q, op_d;

  logic         need_dc, need_ic, need_tlb;
  logic         drained;
  fence_state_e after_drain, after_dc, after_ic;

  assign need_dc  = DcacheFlushOnFence || ((op_q == FENCE_I) && !WtCache);
  assign need_ic  = (op_q == FENCE_I);
  assign need_tlb = (op_q == SFENCE_VMA);

  // A write-back D$ has no write buffer, so its empty flag is don't-care.
  assign drained  = sb_empty_i && (wbuf_empty_i || !WtCache);

  assign after_ic    = need_tlb ? FLUSH_TLB : DONE;
  assign after_dc    = need_ic  ? INV_IC    : after_ic;
  assign after_drain = need_dc  ? FLUSH_DC  : after_dc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= FENCE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    op_d                = op_q;
    fence_ready_o       = 1'b0;
    done_o              = 1'b0;
    dcache_flush_o      = 1'b0;
    dcache_invalidate_o = 1'b0;
    icache_flush_o      = 1'b0;
    tlb_flush_o         = 1'b0;
    case (state_q)
      IDLE: begin
        fence_ready_o = 1'b1;
        if (fence_valid_i) begin
          op_d    = decode_op(fence_op_i);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          state_d = after_drain;
        end
      end
      FLUSH_DC: begin
        dcache_flush_o      = 1'b1;
        dcache_invalidate_o = DcacheInvalidateOnFlush;
        if (dcache_flush_ack_i) begin
          state_d = after_dc;
        end
      end
      INV_IC: begin
        icache_flush_o = 1'b1;
        state_d        = after_ic;
      end
      FLUSH_TLB: begin
        tlb_flush_o = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign halt_o = busy_o;

`ifdef FENCE_SEQ_PERF_EN
  fence_seq_cycle_cnt #(
    .CntWidth (CntWidth)
  ) u_cycle_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (fence_ready_o && fence_valid_i),
    .inc_i    (busy_o),
    .cap_i    (done_o),
    .cycles_o (fence_cycles_o)
  );
`endif

endmodule

// File: tb/tb_fence_flush_seq.sv
// Bench for fence_flush_seq. Three instances run in lockstep on shared stimulus:
//   dut0: defaults (write-through, no D$ flush)
//   dut1: WtCache=0 (FENCE.I needs a D$ flush)
//   dut2: DcacheFlushOnFence=1, DcacheInvalidateOnFlush=1
// A phase-list reference model predicts every output of every instance.
module tb_fence_flush_seq;

  localparam bit [2:0] CFG_WT   = 3'b101;
  localparam bit [2:0] CFG_DFL  = 3'b100;
  localparam bit [2:0] CFG_DINV = 3'b100;

  localparam int P_DRAIN = 1;
  localparam int P_DC    = 2;
  localparam int P_IC    = 3;
  localparam int P_TLB   = 4;
  localparam int P_DONE  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       fence_valid;
  logic [1:0] fence_op;
  logic       sb_empty, wbuf_empty, ack;

  logic rdy[3], done[3], busy[3], halt[3], dcf[3], dci[3], icf[3], tlb[3];
`ifdef FENCE_SEQ_PERF_EN
  logic [15:0] cyc[3];
`endif

  int vectors    = 0;
  int miscompares = 0;

  // reference model: per instance, list of phases still to visit
  int m_list[3][6];
  int m_len[3];
  int m_idx[3];
  bit m_active[3];
  int m_cnt[3];
  int m_cyc[3];

  always #5 clk = ~clk;

  fence_flush_seq dut0 (
    .clk_i(clk), .rst_i(rst), .fence_valid_i(fence_valid), .fence_op_i(fence_op),
    .fence_ready_o(rdy[0]), .done_o(done[0]), .busy_o(busy[0]), .halt_o(halt[0]),
    .sb_empty_i(sb_empty), .wbuf_empty_i(wbuf_empty),
    .dcache_flush_o(dcf[0]), .dcache_invalidate_o(dci[0]), .dcache_flush_ack_i(ack),
    .icache_flush_o(icf[0]), .tlb_flush_o(tlb[0])
`ifdef FENCE_SEQ_PERF_EN
    , .fence_cycles_o(cyc[0])
`endif
  );

  fence_flush_seq #(.WtCache(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .fence_valid_i(fence_valid), .fence_op_i(fence_op),
    .fence_ready_o(rdy[1]), .done_o(done[1]), .busy_o(busy[1]), .halt_o(halt[1]),
    .sb_empty_i(sb_empty), .wbuf_empty_i(wbuf_empty),
    .dcache_flush_o(dcf[1]), .dcache_invalidate_o(dci[1]), .dcache_flush_ack_i(ack),
    .icache_flush_o(icf[1]), .tlb_flush_o(tlb[1])
`ifdef FENCE_SEQ_PERF_EN
    , .fence_cycles_o(cyc[1])
`endif
  );

  fence_flush_seq #(.DcacheFlushOnFence(1'b1), .DcacheInvalidateOnFlush(1'b1)) dut2 (
    .clk_i(clk), .rst_i(rst), .fence_valid_i(fence_valid), .fence_op_i(fence_op),
    .fence_ready_o(rdy[2]), .done_o(done[2]), .busy_o(busy[2]), .halt_o(halt[2]),
    .sb_empty_i(sb_empty), .wbuf_empty_i(wbuf_empty),
    .dcache_flush_o(dcf[2]), .dcache_invalidate_o(dci[2]), .dcache_flush_ack_i(ack),
    .icache_flush_o(icf[2]), .tlb_flush_o(tlb[2])
`ifdef FENCE_SEQ_PERF_EN
    , .fence_cycles_o(cyc[2])
`endif
  );

  // {ready, done, busy, halt, dc_flush, dc_inv, ic_flush, tlb_flush}
  function automatic logic [7:0] obs(input int k);
    return {rdy[k], done[k], busy[k], halt[k], dcf[k], dci[k], icf[k], tlb[k]};
  endfunction

  function automatic logic [7:0] exp_vec(input int k);
    if (!m_active[k]) return 8'h80;
    case (m_list[k][m_idx[k]])
      P_DRAIN: return 8'h30;
      P_DC:    return CFG_DINV[k] ? 8'h3C : 8'h38;
      P_IC:    return 8'h32;
      P_TLB:   return 8'h31;
      default: return 8'h70;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_active[k] = 1'b0;
      m_idx[k]    = 0;
      m_len[k]    = 0;
      m_cnt[k]    = 0;
      m_cyc[k]    = 0;
    end
  endtask

  // Advance the model across one rising edge, using the inputs of the ending cycle.
  task automatic model_step();
    int op;
    int ph;
    bit adv;
    if (rst) begin
      model_clear();
      return;
    end
    op = (fence_op == 2'd3) ? 0 : int'(fence_op);
    for (int k = 0; k < 3; k++) begin
      if (!m_active[k]) begin
        if (fence_valid) begin
          m_len[k] = 0;
          m_list[k][m_len[k]++] = P_DRAIN;
          if (CFG_DFL[k] || (op == 1 && !CFG_WT[k])) m_list[k][m_len[k]++] = P_DC;
          if (op == 1) m_list[k][m_len[k]++] = P_IC;
          if (op == 2) m_list[k][m_len[k]++] = P_TLB;
          m_list[k][m_len[k]++] = P_DONE;
          m_idx[k]    = 0;
          m_active[k] = 1'b1;
          m_cnt[k]    = 0;
        end
      end else begin
        ph = m_list[k][m_idx[k]];
        if (m_cnt[k] < 65535) m_cnt[k]++;
        case (ph)
          P_DRAIN: adv = sb_empty && (wbuf_empty || !CFG_WT[k]);
          P_DC:    adv = ack;
          default: adv = 1'b1;
        endcase
        if (ph == P_DONE) begin
          m_cyc[k]    = m_cnt[k];
          m_active[k] = 1'b0;
        end else if (adv) begin
          m_idx[k]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic settle();
    int n = 0;
    fence_valid = 1'b0;
    sb_empty    = 1'b1;
    wbuf_empty  = 1'b1;
    while ((m_active[0] || m_active[1] || m_active[2]) && n < 40) begin
      ack = ~ack;
      tick();
      n++;
    end
    ack = 1'b0;
    vectors++;
    if (m_active[0] || m_active[1] || m_active[2]) begin
      miscompares++;
      $display("FAIL settle: sequencers still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fence_valid = 1'b0; fence_op = 2'd0;
    sb_empty = 1'b1; wbuf_empty = 1'b1; ack = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs(k) !== 8'h80) begin
        miscompares++;
        $display("FAIL reset dut%0d: got %b required %b", k, obs(k), 8'h80);
      end
`ifdef FENCE_SEQ_PERF_EN
      vectors++;
      if (cyc[k] !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_cycles dut%0d: got %0d required 0", k, cyc[k]);
      end
`endif
    end
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs(k) !== exp_vec(k)) begin
        miscompares++;
        $display("FAIL post_reset dut%0d: got %b required %b", k, obs(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_fence_latency();
    logic [7:0] want0[4] = '{8'h80, 8'h30, 8'h70, 8'h80};
    fence_valid = 1'b1; fence_op = 2'd0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (obs(0) !== want0[i]) begin
        miscompares++;
        $display("FAIL fence_latency T+%0d: got %b required %b", i, obs(0), want0[i]);
      end
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL fence_model dut%0d T+%0d: got %b required %b", k, i, obs(k), exp_vec(k));
        end
      end
      if (i < 3) tick();
      fence_valid = 1'b0;
    end
`ifdef FENCE_SEQ_PERF_EN
    vectors++;
    if (cyc[0] !== 16'd2) begin
      miscompares++;
      $display("FAIL fence_cycles: got %0d required 2", cyc[0]);
    end
`endif
    settle();
  endtask

  task automatic test_fence_i_wb();
    int dcf_n = 0, dci_n = 0, icf_n = 0, ic_at = -1, done_at = -1;
    fence_valid = 1'b1; fence_op = 2'd1; ack = 1'b0;
    tick();
    fence_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL fence_i_model dut%0d cyc %0d: got %b required %b", k, i, obs(k), exp_vec(k));
        end
      end
      dcf_n += int'(dcf[1]);
      dci_n += int'(dci[1]);
      icf_n += int'(icf[1]);
      if (icf[1]) ic_at = i;
      if (done[1]) done_at = i;
      ack = (i == 4);
      tick();
    end
    ack = 1'b0;
    vectors += 4;
    if (dcf_n !== 4) begin miscompares++; $display("FAIL fence_i_dc_cycles: got %0d required 4", dcf_n); end
    if (dci_n !== 0) begin miscompares++; $display("FAIL fence_i_dc_inv: got %0d required 0", dci_n); end
    if (icf_n !== 1 || ic_at !== 5) begin
      miscompares++;
      $display("FAIL fence_i_ic_pulse: got %0d pulses at %0d required 1 at 5", icf_n, ic_at);
    end
    if (done_at !== 6) begin miscompares++; $display("FAIL fence_i_done: got cycle %0d required 6", done_at); end
    settle();
  endtask

  task automatic test_sfence_drain();
    logic [7:0] want;
    fence_valid = 1'b1; fence_op = 2'd2; sb_empty = 1'b0;
    tick();
    fence_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      want = (i <= 5) ? 8'h30 : (i == 6) ? 8'h31 : (i == 7) ? 8'h70 : 8'h80;
      vectors++;
      if (obs(0) !== want) begin
        miscompares++;
        $display("FAIL sfence_drain cyc %0d: got %b required %b", i, obs(0), want);
      end
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL sfence_model dut%0d cyc %0d: got %b required %b", k, i, obs(k), exp_vec(k));
        end
      end
      sb_empty = (i >= 5);
      tick();
    end
    settle();
  endtask

  task automatic test_flush_inv();
    logic [7:0] want;
    ack = 1'b1;
    tick();
    vectors++;
    if (obs(2) !== 8'h80) begin
      miscompares++;
      $display("FAIL stray_ack_idle: got %b required %b", obs(2), 8'h80);
    end
    ack = 1'b0; fence_valid = 1'b1; fence_op = 2'd0;
    tick();
    fence_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      want = (i == 0) ? 8'h30 : (i <= 3) ? 8'h3C : (i == 4) ? 8'h70 : 8'h80;
      vectors++;
      if (obs(2) !== want) begin
        miscompares++;
        $display("FAIL flush_inv cyc %0d: got %b required %b", i, obs(2), want);
      end
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL flush_inv_model dut%0d cyc %0d: got %b required %b", k, i, obs(k), exp_vec(k));
        end
      end
      ack = (i == 3);
      tick();
    end
    ack = 1'b0;
    settle();
  endtask

  task automatic test_reset_mid();
    fence_valid = 1'b1; fence_op = 2'd0; ack = 1'b0;
    tick();
    fence_valid = 1'b0;
    tick();
    vectors++;
    if (obs(2) !== 8'h3C) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got %b required %b", obs(2), 8'h3C);
    end
    rst = 1'b1;
    model_clear();
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs(k) !== 8'h80) begin
        miscompares++;
        $display("FAIL reset_mid_abort dut%0d: got %b required %b", k, obs(k), 8'h80);
      end
    end
    @(negedge clk);
    rst = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs(k) !== 8'h80) begin
        miscompares++;
        $display("FAIL reset_mid_late_ack dut%0d: got %b required %b", k, obs(k), 8'h80);
      end
    end
    fence_valid = 1'b1;
    tick();
    fence_valid = 1'b0;
    tick();
    vectors++;
    if (obs(0) !== 8'h70) begin
      miscompares++;
      $display("FAIL reset_mid_recover: got %b required %b", obs(0), 8'h70);
    end
    settle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] want0[7] = '{8'h80, 8'h30, 8'h70, 8'h80, 8'h30, 8'h70, 8'h80};
    fence_valid = 1'b1; fence_op = 2'd3; ack = 1'b1;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (obs(0) !== want0[i]) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d: got %b required %b", i, obs(0), want0[i]);
      end
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL b2b_model dut%0d cyc %0d: got %b required %b", k, i, obs(k), exp_vec(k));
        end
      end
      if (i == 5) fence_valid = 1'b0;
      tick();
    end
    ack = 1'b0;
    settle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL random dut%0d cyc %0d: got %b required %b", k, i, obs(k), exp_vec(k));
        end
`ifdef FENCE_SEQ_PERF_EN
        vectors++;
        if (cyc[k] !== 16'(m_cyc[k])) begin
          miscompares++;
          $display("FAIL random_cycles dut%0d cyc %0d: got %0d required %0d", k, i, cyc[k], m_cyc[k]);
        end
`endif
      end
      fence_valid = ($urandom_range(1, 0) == 1);
      fence_op    = 2'($urandom_range(3, 0));
      sb_empty    = ($urandom_range(9, 0) < 7);
      wbuf_empty  = ($urandom_range(9, 0) < 7);
      ack         = ($urandom_range(9, 0) < 3);
      tick();
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_fence_latency();
    test_fence_i_wb();
    test_sfence_drain();
    test_flush_inv();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
